// File: rtl/csa_seq_adder_pkg.sv
// Shared types and sizing helpers for the sequential conditional-sum adder.
package csa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 64;
    localparam int unsigned DEF_SLICE = 16;

    // Number of slice cycles for a given operand width.
    function automatic int unsigned nslice_f(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

    // Slice index width, never narrower than one bit.
    function automatic int unsigned idxw_f(input int unsigned nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/csa_seq_adder_adder_block.sv
// Conditional-sum adder slice: every bit computes sum/carry for both carry-in
// values, then blocks pairwise merge, the lower block's carry selecting the upper.
module AdderBlock #(
    parameter int unsigned size = 16
) (
    input  logic [size-1:0] A,
    input  logic [size-1:0] B,
    input  logic            Cin,
    output logic [size-1:0] Sum,
    output logic            Cout
);

    localparam int unsigned LVLS = (size <= 1) ? 1 : $clog2(size);

    // Per bit: sum for block carry-in 0/1, and carry out of the enclosing block for carry-in 0/1.
    logic [size-1:0] w_s0, w_s1, w_k0, w_k1;
    logic [size-1:0] w_n_s0, w_n_s1, w_n_k0, w_n_k1;

    // Start index of the merged block of width 2<<l that contains bit i.
    function automatic int blk_lo(input int i, input int l);
        return (i / (2 << l)) * (2 << l);
    endfunction

    // Conditional-sum tree: log2(size) merge levels, final select by Cin.
    always_comb begin
        w_s0   = A ^ B;
        w_s1   = ~(A ^ B);
        w_k0   = A & B;
        w_k1   = A | B;
        w_n_s0 = '0;
        w_n_s1 = '0;
        w_n_k0 = '0;
        w_n_k1 = '0;
        for (int l = 0; l < int'(LVLS); l++) begin
            w_n_s0 = w_s0;
            w_n_s1 = w_s1;
            w_n_k0 = w_k0;
            w_n_k1 = w_k1;
            for (int i = 0; i < int'(size); i++) begin
                if ((blk_lo(i, l) + (1 << l)) < int'(size)) begin
                    if (i >= blk_lo(i, l) + (1 << l)) begin
                        w_n_s0[i] = w_k0[blk_lo(i, l)] ? w_s1[i] : w_s0[i];
                        w_n_s1[i] = w_k1[blk_lo(i, l)] ? w_s1[i] : w_s0[i];
                    end
                    w_n_k0[i] = w_k0[blk_lo(i, l)] ? w_k1[blk_lo(i, l) + (1 << l)]
                                                   : w_k0[blk_lo(i, l) + (1 << l)];
                    w_n_k1[i] = w_k1[blk_lo(i, l)] ? w_k1[blk_lo(i, l) + (1 << l)]
                                                   : w_k0[blk_lo(i, l) + (1 << l)];
                end
            end
            w_s0 = w_n_s0;
            w_s1 = w_n_s1;
            w_k0 = w_n_k0;
            w_k1 = w_n_k1;
        end
        Sum  = Cin ? w_s1 : w_s0;
        Cout = Cin ? w_k1[0] : w_k0[0];
    end

endmodule

// File: rtl/csa_seq_adder.sv
// Multi-cycle wide add/subtract: one SLICE-bit conditional-sum slice per cycle,
// LSB slice first, with the inter-slice carry held in a register.
module csa_seq_adder
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy
);

    localparam int unsigned NSLICE = nslice_f(WIDTH, SLICE);
    localparam int unsigned IDXW   = idxw_f(NSLICE);

    state_t                        r_state, w_state_nxt;
    logic [NSLICE-1:0][SLICE-1:0]  r_op_a, w_op_a_nxt;
    logic [NSLICE-1:0][SLICE-1:0]  r_op_b, w_op_b_nxt;
    logic [NSLICE-1:0][SLICE-1:0]  r_sum, w_sum_nxt;
    logic [IDXW-1:0]               r_idx, w_idx_nxt;
    logic                          r_carry, w_carry_nxt;
    logic                          r_cout, w_cout_nxt;
    logic                          r_ovf, w_ovf_nxt;
    logic                          r_out_valid, w_out_valid_nxt;
    logic                          r_in_ready, w_in_ready_nxt;
    logic                          r_busy, w_busy_nxt;

    logic [SLICE-1:0]              w_a_slice, w_b_slice, w_slice_sum;
    logic                          w_slice_cout;
    logic                          w_last;

    assign w_a_slice = r_op_a[r_idx];
    assign w_b_slice = r_op_b[r_idx];
    assign w_last    = (r_idx == IDXW'(NSLICE - 1));

    AdderBlock #(.size(SLICE)) u_slice (
        .A    (w_a_slice),
        .B    (w_b_slice),
        .Cin  (r_carry),
        .Sum  (w_slice_sum),
        .Cout (w_slice_cout)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op_a      <= w_op_a_nxt;
            r_op_b      <= w_op_b_nxt;
            r_sum       <= w_sum_nxt;
            r_idx       <= w_idx_nxt;
            r_carry     <= w_carry_nxt;
            r_cout      <= w_cout_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and next-datapath logic; flush overrides any handshake.
    always_comb begin
        w_state_nxt     = r_state;
        w_op_a_nxt      = r_op_a;
        w_op_b_nxt      = r_op_b;
        w_sum_nxt       = r_sum;
        w_idx_nxt       = r_idx;
        w_carry_nxt     = r_carry;
        w_cout_nxt      = r_cout;
        w_ovf_nxt       = r_ovf;
        w_out_valid_nxt = r_out_valid;

        if (flush) begin
            w_state_nxt     = ST_IDLE;
            w_sum_nxt       = '0;
            w_idx_nxt       = '0;
            w_carry_nxt     = 1'b0;
            w_cout_nxt      = 1'b0;
            w_ovf_nxt       = 1'b0;
            w_out_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w_op_a_nxt  = A;
                        w_op_b_nxt  = Sub ? ~B : B;
                        w_carry_nxt = Sub ? 1'b1 : Cin;
                        w_idx_nxt   = '0;
                        w_sum_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_sum_nxt[r_idx] = w_slice_sum;
                    w_carry_nxt      = w_slice_cout;
                    w_idx_nxt        = r_idx + IDXW'(1);
                    if (w_last) begin
                        w_idx_nxt       = '0;
                        w_cout_nxt      = w_slice_cout;
                        w_ovf_nxt       = (r_op_a[NSLICE-1][SLICE-1] == r_op_b[NSLICE-1][SLICE-1]) &&
                                          (w_slice_sum[SLICE-1] != r_op_a[NSLICE-1][SLICE-1]);
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            endcase
        end

        w_in_ready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign Sum       = r_sum;
    assign Cout      = r_cout;
    assign Ovf       = r_ovf;

endmodule

// File: tb/tb_csa_seq_adder.sv
// Randomized and directed bench for csa_seq_adder against an arithmetic reference model.
module tb_csa_seq_adder;

    localparam int unsigned W  = 64;
    localparam int unsigned NS = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         Sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csa_seq_adder #(.WIDTH(W), .SLICE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, cout, sum} from plain unsigned/signed arithmetic.
    function automatic logic [W+1:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin, input logic sub);
        logic [W:0]          u;
        logic signed [W+1:0] sx;
        if (sub) begin
            u[W-1:0] = a - b;
            u[W]     = (a >= b);
            sx = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            sx = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed({{(W+1){1'b0}}, cin});
        end
        return {sx[W] != sx[W-1], u};
    endfunction

    // Protocol-level model: 0 idle, 1 computing, 2 result held.
    int           m_state = 0;
    int           m_cnt   = 0;
    logic         m_zero  = 1'b1;
    logic         m_hold  = 1'b0;
    logic [W-1:0] m_sum   = '0;
    logic         m_cout  = 1'b0;
    logic         m_ovf   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_zero = 1'b1; m_hold = 1'b0;
        end else if (flush) begin
            m_state = 0; m_zero = 1'b1; m_hold = 1'b0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    {m_ovf, m_cout, m_sum} = ref_calc(A, B, Cin, Sub);
                    m_state = 1; m_cnt = NS; m_zero = 1'b0; m_hold = 1'b0;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_state = 2;
                end
                default: if (out_ready) begin
                    m_state = 0; m_hold = 1'b1;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("out_valid", W'(out_valid), W'(m_state == 2));
        chk("in_ready",  W'(in_ready),  W'(m_state == 0));
        chk("busy",      W'(busy),      W'(m_state != 0));
        if (m_state == 2 || m_hold) begin
            chk("sum",  Sum,        m_sum);
            chk("cout", W'(Cout),   W'(m_cout));
            chk("ovf",  W'(Ovf),    W'(m_ovf));
        end
        if (m_zero && m_state == 0) begin
            chk("sum_zero",  Sum,      '0);
            chk("cout_zero", W'(Cout), '0);
            chk("ovf_zero",  W'(Ovf),  '0);
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int n;
        @(posedge clk); #1;
        A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        send(a, b, cin, sub);
        wait_valid(lat);
        chk({name, "_latency"}, W'(lat), W'(NS));
        chk({name, "_sum"},  Sum,      es);
        chk({name, "_cout"}, W'(Cout), W'(ec));
        chk({name, "_ovf"},  W'(Ovf),  W'(eo));
        consume();
    endtask

    logic [W+1:0] pin;
    logic [W-1:0] held;
    int           lat;

    function automatic logic [W-1:0] rnd_op();
        case ($urandom % 5)
            0: return '1;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        // Pin the reference model itself.
        pin = ref_calc(64'd5, 64'd7, 1'b0, 1'b1);
        chk("pin_sub", pin[W-1:0], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("pin_sub_flags", W'(pin[W+1:W]), W'(2'b00));
        pin = ref_calc(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        chk("pin_ovf_flags", W'(pin[W+1:W]), W'(2'b10));
        pin = ref_calc('1, 64'd0, 1'b1, 1'b0);
        chk("pin_ripple_flags", W'(pin[W+1:W]), W'(2'b01));

        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  W'(in_ready),  W'(1));
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_busy",      W'(busy),      '0);
        chk("rst_sum",       Sum,           '0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        run_op("t1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        run_op("t2", '1, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
        run_op("t3a", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op("t3b", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        // Backpressure with a pending new request.
        send(64'h1234_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0, 1'b0);
        wait_valid(lat);
        chk("bp_latency", W'(lat), W'(NS));
        held = Sum;
        chk("bp_sum", held, 64'h1234_0000_0000_0003);
        A = 64'd100; B = 64'd23; Cin = 1'b0; Sub = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", W'(in_ready), '0);
            chk("bp_hold_sum", Sum, held);
        end
        consume();
        chk("bp_idle_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accepted", W'(busy), W'(1));
        wait_valid(lat);
        chk("bp2_latency", W'(lat), W'(NS));
        chk("bp2_sum", Sum, 64'd77);
        chk("bp2_cout", W'(Cout), W'(1));
        consume();

        // Asynchronous reset at slice index 2.
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", W'(out_valid), '0);
        chk("ar_busy",      W'(busy),      '0);
        chk("ar_in_ready",  W'(in_ready),  W'(1));
        chk("ar_sum",       Sum,           '0);
        chk("ar_cout",      W'(Cout),      '0);
        chk("ar_ovf",       W'(Ovf),       '0);
        @(negedge clk); rst_n = 1'b1;
        run_op("ar_next", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);

        // Flush against a result handshake in DONE.
        send(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0);
        wait_valid(lat);
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; flush = 1'b0;
        chk("fd_out_valid", W'(out_valid), '0);
        chk("fd_in_ready",  W'(in_ready),  W'(1));
        chk("fd_sum",       Sum,           '0);

        // Flush during RUN: that operation never completes.
        send(64'd9, 64'd9, 1'b0, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int k = 0; k < NS + 4; k++) begin
            chk("fr_no_valid", W'(out_valid), '0);
            @(posedge clk); #1;
        end
        run_op("fr_next", 64'd10, 64'd11, 1'b1, 1'b0, 64'd22, 1'b0, 1'b0);

        // Random traffic checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 3) != 0;
            A         = rnd_op();
            B         = rnd_op();
            Cin       = $urandom % 2;
            Sub       = $urandom % 2;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 60) == 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (NS + 3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
